// File: rtl/cheshire_uart_rx_monitor_if.sv
// Byte stream carrying received UART data from the monitor to its consumer.
// master = byte source (the receiver), slave = consumer.
interface cheshire_uart_rx_monitor_if;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;

  modport master (output data_o, valid_o, input ready_i);
  modport slave  (input data_o, valid_o, output ready_i);
endinterface

// File: rtl/cheshire_uart_rx_monitor.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a first-word-fall-through
// byte FIFO, with framing/overflow/parity error pulses and a saturating drop counter.
module cheshire_uart_rx_monitor #(
  parameter int unsigned ClkFreqHz = 50_000_000,
  parameter int unsigned BaudRate  = 115200,
  parameter int unsigned FifoDepth = 16,
  parameter int unsigned StatWidth = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         rx_i,
  cheshire_uart_rx_monitor_if.master   stream,
  output logic [$clog2(FifoDepth):0]   fill_o,
  output logic                         busy_o,
  output logic                         frame_err_o,
  output logic                         overflow_o,
  output logic [StatWidth-1:0]         drop_cnt_o,
  output logic                         parity_err_o
);

  localparam int unsigned BitCycles  = ClkFreqHz / BaudRate;
  localparam int unsigned HalfCycles = BitCycles / 2;
  localparam int unsigned CntW       = $clog2(BitCycles);
  localparam int unsigned PtrW       = $clog2(FifoDepth);

  localparam logic [CntW-1:0] BitLast  = CntW'(BitCycles - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(HalfCycles - 1);
  localparam logic [PtrW:0]   FullLvl  = (PtrW + 1)'(FifoDepth);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_t;

  state_t          state;
  logic [CntW-1:0] cnt;
  logic [2:0]      idx;
  logic [7:0]      shreg;
  logic            rx_q1, rx_s, rx_prev;
  logic            push_req;
  logic [7:0]      push_data;
`ifdef UART_RX_PARITY_EN
  logic            par_bad;
  logic            par_err_q;
`endif

  // Reset to the idle level so leaving reset never looks like a start bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_q1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_q1   <= rx_i;
      rx_s    <= rx_q1;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      push_req    <= 1'b0;
      push_data   <= '0;
      frame_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad     <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      push_req    <= 1'b0;
      frame_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (rx_prev && !rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HalfLast) begin
            cnt   <= '0;
            idx   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
        DATA: begin
          if (cnt == BitLast) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            idx   <= idx + 3'd1;
            if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == BitLast) begin
            cnt <= '0;
            if (rx_s != ^shreg) begin
              par_bad   <= 1'b1;
              par_err_q <= 1'b1;
            end
            state <= STOP;
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
`endif
        STOP: begin
          if (cnt == BitLast) begin
            cnt <= '0;
            if (rx_s) begin
`ifdef UART_RX_PARITY_EN
              push_req <= !par_bad;
`else
              push_req <= 1'b1;
`endif
              push_data <= shreg;
              state     <= IDLE;
            end else begin
              frame_err_o <= 1'b1;
              state       <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
        WAIT_IDLE: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o = (state != IDLE);

`ifdef UART_RX_PARITY_EN
  assign parity_err_o = par_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

  logic [7:0]      mem [FifoDepth];
  logic [PtrW-1:0] wptr, rptr;
  logic            full, pop, accept;

  assign full   = (fill_o == FullLvl);
  assign pop    = stream.valid_o && stream.ready_i;
  // A pop frees the slot in the same cycle, so a full FIFO still takes a concurrent push.
  assign accept = push_req && (!full || pop);

  assign stream.valid_o = (fill_o != '0);
  assign stream.data_o  = stream.valid_o ? mem[rptr] : '0;

  always_ff @(posedge clk_i) begin
    if (accept) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr       <= '0;
      rptr       <= '0;
      fill_o     <= '0;
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      overflow_o <= 1'b0;
      if (accept) wptr <= wptr + PtrW'(1);
      if (pop)    rptr <= rptr + PtrW'(1);
      case ({accept, pop})
        2'b10:   fill_o <= fill_o + (PtrW + 1)'(1);
        2'b01:   fill_o <= fill_o - (PtrW + 1)'(1);
        default: fill_o <= fill_o;
      endcase
      if (push_req && !accept) begin
        overflow_o <= 1'b1;
        if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + StatWidth'(1);
      end
    end
  end

endmodule

// File: tb/tb_cheshire_uart_rx_monitor.sv
// Bench for cheshire_uart_rx_monitor: table-driven frames plus hand-written corner sequences,
// received bytes checked against a queue of expected bytes.
module tb_cheshire_uart_rx_monitor;
  localparam int unsigned ClkHz = 1_000_000;
  localparam int unsigned Baud  = 100_000;
  localparam int unsigned Bit   = 10;
  localparam int unsigned Half  = 5;
  localparam int unsigned Depth = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [4:0] fill;
  logic       busy, fe, ovf, pe;
  logic [7:0] drop;

  always #5 clk = ~clk;

  cheshire_uart_rx_monitor_if sif ();

  cheshire_uart_rx_monitor #(
    .ClkFreqHz(ClkHz),
    .BaudRate (Baud),
    .FifoDepth(Depth),
    .StatWidth(8)
  ) u_dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_i        (rx),
    .stream      (sif),
    .fill_o      (fill),
    .busy_o      (busy),
    .frame_err_o (fe),
    .overflow_o  (ovf),
    .drop_cnt_o  (drop),
    .parity_err_o(pe)
  );

  int tests = 0;
  int fails = 0;
  int fe_cnt = 0, ovf_cnt = 0, pe_cnt = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       push;
    int         fe;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, input logic par_ok);
    rx = 1'b0;
    cyc(Bit);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      cyc(Bit);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^data) ^ !par_ok;
    cyc(Bit);
`endif
    rx = stop;
    cyc(Bit);
    rx = 1'b1;
    cyc(Bit);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      cyc(1);
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (fe)  fe_cnt++;
      if (ovf) ovf_cnt++;
      if (pe)  pe_cnt++;
      if (sif.valid_o && sif.ready_i) begin
        if (exp_q.size() == 0) check("unexpected_pop", {24'd0, sif.data_o}, 32'hFFFF_FFFF);
        else check("pop_data", {24'd0, sif.data_o}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int fe0, ovf0, pe0, n;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 0};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 0};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 0};
    vecs[3] = '{8'h55, 1'b0, 1'b0, 1};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 0};

    rst = 1'b0;
    rx = 1'b1;
    sif.ready_i = 1'b0;
    #1 rst = 1'b1;
    cyc(3);
    check("rst_fill", fill, 0);
    check("rst_valid", sif.valid_o, 0);
    check("rst_data", sif.data_o, 0);
    check("rst_busy", busy, 0);
    check("rst_flags", {fe, ovf, pe}, 0);
    check("rst_drop", drop, 0);
    rst = 1'b0;
    cyc(Bit);

    // Table-driven frames with the consumer always ready.
    sif.ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      fe0 = fe_cnt; ovf0 = ovf_cnt; pe0 = pe_cnt;
      if (vecs[i].push) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop, 1'b1);
      wait_drain();
      check("vec_frame_err", fe_cnt - fe0, vecs[i].fe);
      check("vec_overflow", ovf_cnt - ovf0, 0);
      check("vec_parity", pe_cnt - pe0, 0);
      check("vec_busy", busy, 0);
      check("vec_fill", fill, 0);
    end

    // Fill the FIFO, drop one byte, then drain in order.
    sif.ready_i = 1'b0;
    ovf0 = ovf_cnt;
    for (int b = 0; b <= 16; b++) begin
      if (b < 16) exp_q.push_back(8'(b));
      send_frame(8'(b), 1'b1, 1'b1);
    end
    check("full_fill", fill, 16);
    check("full_overflow", ovf_cnt - ovf0, 1);
    check("full_drop_cnt", drop, 1);
    check("full_head", sif.data_o, 8'h00);
    sif.ready_i = 1'b1;
    wait_drain();
    check("drained_fill", fill, 0);
    check("drained_valid", sif.valid_o, 0);

    // Bad stop bit followed by a held-low line.
    fe0 = fe_cnt;
    rx = 1'b0;
    cyc(Bit);
    for (int i = 0; i < 8; i++) begin
      rx = (8'h55 >> i) & 8'h01;
      cyc(Bit);
    end
`ifdef UART_RX_PARITY_EN
    rx = ^8'h55;
    cyc(Bit);
`endif
    rx = 1'b0;
    cyc(Bit + 30);
    check("break_frame_err", fe_cnt - fe0, 1);
    check("break_busy", busy, 1);
    check("break_fill", fill, 0);
    rx = 1'b1;
    cyc(Bit);
    check("break_idle", busy, 0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b1);
    wait_drain();

    // Short low glitch must not start a frame.
    fe0 = fe_cnt; ovf0 = ovf_cnt; pe0 = pe_cnt;
    rx = 1'b0;
    cyc(3);
    check("glitch_busy_seen", busy, 1);
    rx = 1'b1;
    n = 0;
    while (busy && n < 20) begin
      cyc(1);
      n++;
    end
    check("glitch_busy_bound", (n <= Half + 2), 1);
    cyc(Bit);
    check("glitch_fill", fill, 0);
    check("glitch_flags", (fe_cnt - fe0) + (ovf_cnt - ovf0) + (pe_cnt - pe0), 0);

    // Reset mid-frame with bytes buffered.
    sif.ready_i = 1'b0;
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    check("prerst_fill", fill, 2);
    rx = 1'b0;
    cyc(Bit);
    rx = 1'b1;
    cyc(Bit * 4 + 5);
    check("prerst_busy", busy, 1);
    rst = 1'b1;
    cyc(2);
    check("midrst_fill", fill, 0);
    check("midrst_valid", sif.valid_o, 0);
    check("midrst_busy", busy, 0);
    check("midrst_drop", drop, 0);
    rst = 1'b0;
    cyc(Bit * 6);
    check("postrst_fill", fill, 0);
    sif.ready_i = 1'b1;
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1'b1);
    wait_drain();

`ifdef UART_RX_PARITY_EN
    pe0 = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    cyc(Bit);
    check("par_bad_pulse", pe_cnt - pe0, 1);
    check("par_bad_fill", fill, 0);
    pe0 = pe_cnt;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    wait_drain();
    check("par_good_pulse", pe_cnt - pe0, 0);
`endif

    cyc(5);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
